// File: rtl/decode_pipe.sv
// decode_pipe: instruction-decode stage with register file and ID/EX register.
//
// Register file: REG_N x DATA_W, every index writable (including 0).
// Reads are combinational with write-first bypass from the writeback port.
// Operand 1 can be replaced by inPort when ctrlIn[IN_SEL_BIT] is set.
// ID/EX register priority: flush > stall > capture (inValid=0 loads a bubble).
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   inValid, ctrlIn          decoded instruction present, control word
//   Rsrc1, Rsrc2, RdstIn     source / destination register indices
//   inPort                   external input port value
//   regWrite, wbRdst,
//   writeData                writeback port
//   stall, flush             ID/EX hold / bubble insert
//   outValid, signalsOut,
//   readData1, readData2,
//   rdstOut                  registered ID/EX outputs
module decode_pipe #(
  parameter int DATA_W     = 16,
  parameter int REG_N      = 8,
  parameter int SIG_W      = 35,
  parameter int IN_SEL_BIT = 18,
  localparam int AW        = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  input  logic [SIG_W-1:0]  ctrlIn,
  input  logic [AW-1:0]     Rsrc1,
  input  logic [AW-1:0]     Rsrc2,
  input  logic [AW-1:0]     RdstIn,
  input  logic [DATA_W-1:0] inPort,
  input  logic              regWrite,
  input  logic [AW-1:0]     wbRdst,
  input  logic [DATA_W-1:0] writeData,
  input  logic              stall,
  input  logic              flush,
  output logic              outValid,
  output logic [SIG_W-1:0]  signalsOut,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [AW-1:0]     rdstOut
);

  logic [DATA_W-1:0] regs [REG_N];
  logic [DATA_W-1:0] rf1, rf2, op1, op2;

  // Register file; writes proceed regardless of stall/flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
      end
    end else if (regWrite) begin
      regs[wbRdst] <= writeData;
    end
  end

  // Write-first bypass so an instruction decoded in the writeback cycle
  // sees the value being written.
  always_comb begin
    rf1 = regs[Rsrc1];
    rf2 = regs[Rsrc2];
    if (regWrite && (wbRdst == Rsrc1)) rf1 = writeData;
    if (regWrite && (wbRdst == Rsrc2)) rf2 = writeData;
    op1 = ctrlIn[IN_SEL_BIT] ? inPort : rf1;
    op2 = rf2;
  end

  // ID/EX register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid   <= 1'b0;
      signalsOut <= '0;
      readData1  <= '0;
      readData2  <= '0;
      rdstOut    <= '0;
    end else if (flush || (!stall && !inValid)) begin
      outValid   <= 1'b0;
      signalsOut <= '0;
      readData1  <= '0;
      readData2  <= '0;
      rdstOut    <= '0;
    end else if (!stall) begin
      outValid   <= 1'b1;
      signalsOut <= ctrlIn;
      readData1  <= op1;
      readData2  <= op2;
      rdstOut    <= RdstIn;
    end
  end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- DATA_W, 16, data width.
- REG_N, 8, register count (power of two).
- SIG_W, 35, control-word width.
- IN_SEL_BIT, 18, control-word bit selecting inPort as operand 1.
REQ-002 AW = log2(REG_N) throughout.
REQ-003 Ports SHALL be, one per line, as name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- inValid  in  1  decoded instruction present.
- ctrlIn  in  SIG_W  control word from control unit.
- Rsrc1  in  AW  source register 1 index.
- Rsrc2  in  AW  source register 2 index.
- RdstIn  in  AW  destination index of decoded instruction.
- inPort  in  DATA_W  external input port value.
- regWrite  in  1  writeback enable.
- wbRdst  in  AW  writeback register index.
- writeData  in  DATA_W  writeback data.
- stall  in  1  hold ID/EX register.
- flush  in  1  insert bubble into ID/EX register.
- outValid  out  1  registered valid.
- signalsOut  out  SIG_W  registered control word.
- readData1  out  DATA_W  registered operand 1.
- readData2  out  DATA_W  registered operand 2.
- rdstOut  out  AW  registered destination index.

Function
REQ-004 Register file SHALL be REG_N x DATA_W; every register is writable, including index 0.
REQ-005 Write: at rising clk with regWrite=1, reg[wbRdst] <= writeData; writes are unaffected by stall or flush.
REQ-006 Read (combinational): opN = (regWrite && wbRdst==RsrcN) ? writeData : reg[RsrcN] (write-first bypass).
REQ-007 Operand-1 select: op1 = inPort when ctrlIn[IN_SEL_BIT]=1, else the REQ-006 value; op2 is always the REQ-006 value.
REQ-008 ID/EX register SHALL update at rising clk with priority flush > stall > capture.
REQ-009 flush=1: outValid, signalsOut, readData1, readData2 and rdstOut all SHALL become 0.
REQ-010 flush=0, stall=1: all ID/EX outputs SHALL hold their values.
REQ-011 Capture with inValid=1: outValid<=1, signalsOut<=ctrlIn, readData1<=op1, readData2<=op2, rdstOut<=RdstIn.
REQ-012 Capture with inValid=0: ID/EX register SHALL load a bubble, identical to REQ-009.
REQ-013 Latency: decode inputs SHALL appear on outputs exactly 1 cycle later, plus 1 cycle per stalled edge.
REQ-014 Stall over several cycles SHALL hold the captured operands; writes during the stall do not change the held operands.
REQ-015 Simultaneous flush and stall SHALL produce a bubble.
REQ-016 Out-of-range Rsrc/wbRdst indices SHALL NOT occur, since REG_N is a power of two.

Reset
REQ-017 rst=1 SHALL asynchronously clear all REG_N registers and all ID/EX outputs to 0, without waiting for a clock edge.
REQ-018 While rst=1, register-file writes and ID/EX captures SHALL be blocked.
REQ-019 After rst deasserts, the first rising clk SHALL operate normally.

Verification
REQ-020 Basic read: write reg3=0x1234 via regWrite; next cycle Rsrc1=3, inValid=1, ctrlIn=0 -> one cycle later readData1=0x1234, outValid=1.
REQ-021 Bypass: regWrite=1, wbRdst=5, writeData=0xBEEF in the same cycle as Rsrc2=5 -> readData2=0xBEEF next cycle.
REQ-022 inPort select: ctrlIn[18]=1, inPort=0x00A5, Rsrc1=2 (reg2=0x7777) -> readData1=0x00A5, readData2 follows Rsrc2.
REQ-023 Stall then flush: capture instruction A, then stall 2 cycles while changing inputs -> outputs stay at A; then flush=1 with stall=1 -> outValid=0, signalsOut=0.
REQ-024 Async reset: assert rst mid-cycle with outValid=1 and reg4=0x55AA -> outputs 0 before the next edge; after release, a read of reg4 returns 0.
